vga_text_ctrl: RTL and testbench

VGA_TEXT_CTRL -- requirements
Module: vga_text_ctrl

---
 rtl/vga_text_ctrl_if.sv | 9 +
 rtl/vga_text_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_vga_text_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_text_ctrl_if.sv
// Character-write handshake between a text source and vga_text_ctrl.
interface vga_text_ctrl_if;
  logic       ch_valid;
  logic [7:0] ch_data;
  logic       ch_ready;

  modport master (output ch_valid, output ch_data, input ch_ready);
  modport slave  (input ch_valid, input ch_data, output ch_ready);
endinterface

// File: rtl/vga_text_ctrl.sv
// 70x30 text-mode VGA controller: character buffer, cursor writer FSM and 2-stage pixel pipeline.
// Optional blinking cursor underline enabled by defining VGA_TEXT_CURSOR_EN.
module vga_text_ctrl (
  input  logic                  clk,
  input  logic                  rst,
  vga_text_ctrl_if.slave        ch_if,
  input  logic [9:0]            h_addr,
  input  logic [9:0]            v_addr,
  input  logic                  pix_valid,
  output logic [7:0]            font_ascii,
  output logic [3:0]            font_row,
  output logic [3:0]            font_col,
  input  logic                  font_data,
  output logic [23:0]           vga_data
);

  localparam int unsigned COORD_W = 10;
  localparam int unsigned CX_W    = 7;
  localparam int unsigned CY_W    = 5;
  localparam int unsigned ADDR_W  = CY_W + CX_W;
  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam int unsigned COLS    = 70;
  localparam int unsigned ROWS    = 30;
  localparam int unsigned CELL_W  = 9;
  localparam int unsigned CHAR_W  = 8;
  localparam int unsigned GLYPH_W = 4;
  localparam int unsigned RGB_W   = 24;

  localparam logic [CHAR_W-1:0] CH_SPACE = 8'h20;
  localparam logic [CHAR_W-1:0] CH_TILDE = 8'h7E;
  localparam logic [CHAR_W-1:0] CH_LF    = 8'h0A;
  localparam logic [CHAR_W-1:0] CH_BS    = 8'h08;
  localparam logic [RGB_W-1:0]  RGB_FG   = 24'hFFFFFF;
  localparam logic [RGB_W-1:0]  RGB_BG   = 24'h000000;

  typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_LINE} state_e;

  state_e              state_q, state_d;
  logic [CX_W-1:0]     cx_q, cx_d;
  logic [CY_W-1:0]     cy_q, cy_d;
  logic [CX_W-1:0]     clr_x_q, clr_x_d;
  logic [CY_W-1:0]     clr_y_q, clr_y_d;
  logic                ch_ready_q, ch_ready_d;

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [CHAR_W-1:0]   wr_data;
  logic [CHAR_W-1:0]   mem_q [DEPTH];

  logic [CX_W-1:0]     cell_x;
  logic [CY_W-1:0]     cell_y;
  logic [GLYPH_W-1:0]  px, py;
  logic [ADDR_W-1:0]   rd_addr;

  logic [CHAR_W-1:0]   font_ascii_q, font_ascii_d;
  logic [GLYPH_W-1:0]  font_row_q, font_row_d;
  logic [GLYPH_W-1:0]  font_col_q, font_col_d;
  logic                in_text_q, in_text_d;
  logic [RGB_W-1:0]    vga_data_q, vga_data_d;
  logic                pix_on;

  logic                accept;
  logic [CY_W-1:0]     next_row;
  logic                last_col, last_row;

`ifdef VGA_TEXT_CURSOR_EN
  logic                blink_q, blink_d;
  logic [4:0]          frame_cnt_q, frame_cnt_d;
  logic                cur_hit_q, cur_hit_d;
  logic                frame_tick;
`endif

  // Writer: cursor bookkeeping and buffer clears
  always_comb begin
    state_d  = state_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    clr_x_d  = clr_x_q;
    clr_y_d  = clr_y_q;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = CH_SPACE;
    accept   = ch_if.ch_valid && ch_ready_q;
    next_row = (cy_q == CY_W'(ROWS - 1)) ? '0 : cy_q + CY_W'(1);
    last_col = (clr_x_q == CX_W'(COLS - 1));
    last_row = (clr_y_q == CY_W'(ROWS - 1));

    case (state_q)
      CLR_ALL: begin
        wr_en   = 1'b1;
        wr_addr = {clr_y_q, clr_x_q};
        if (last_col) begin
          clr_x_d = '0;
          if (last_row) begin
            clr_y_d = '0;
            cx_d    = '0;
            cy_d    = '0;
            state_d = IDLE;
          end else begin
            clr_y_d = clr_y_q + CY_W'(1);
          end
        end else begin
          clr_x_d = clr_x_q + CX_W'(1);
        end
      end

      IDLE: begin
        if (accept) begin
          if (ch_if.ch_data >= CH_SPACE && ch_if.ch_data <= CH_TILDE) begin
            wr_en   = 1'b1;
            wr_addr = {cy_q, cx_q};
            wr_data = ch_if.ch_data;
            if (cx_q == CX_W'(COLS - 1)) begin
              cx_d    = '0;
              cy_d    = next_row;
              clr_x_d = '0;
              state_d = CLR_LINE;
            end else begin
              cx_d = cx_q + CX_W'(1);
            end
          end else if (ch_if.ch_data == CH_LF) begin
            cx_d    = '0;
            cy_d    = next_row;
            clr_x_d = '0;
            state_d = CLR_LINE;
          end else if (ch_if.ch_data == CH_BS && cx_q != '0) begin
            cx_d    = cx_q - CX_W'(1);
            wr_en   = 1'b1;
            wr_addr = {cy_q, cx_q - CX_W'(1)};
          end
        end
      end

      CLR_LINE: begin
        wr_en   = 1'b1;
        wr_addr = {cy_q, clr_x_q};
        if (last_col) begin
          clr_x_d = '0;
          state_d = IDLE;
        end else begin
          clr_x_d = clr_x_q + CX_W'(1);
        end
      end

      default: begin
        state_d = CLR_ALL;
        clr_x_d = '0;
        clr_y_d = '0;
      end
    endcase

    ch_ready_d = (state_d == IDLE);
  end

  // Display pipeline: stage 0 decode feeding stage 1/2 registers
  always_comb begin
    cell_x       = CX_W'(h_addr / COORD_W'(CELL_W));
    px           = GLYPH_W'(h_addr % COORD_W'(CELL_W));
    cell_y       = CY_W'(v_addr >> 4);
    py           = v_addr[3:0];
    rd_addr      = {cell_y, cell_x};
    font_ascii_d = mem_q[rd_addr];
    font_row_d   = py;
    font_col_d   = px;
    in_text_d    = pix_valid && (h_addr < COORD_W'(COLS * CELL_W));
    pix_on       = in_text_q && font_data;
`ifdef VGA_TEXT_CURSOR_EN
    frame_tick   = pix_valid && (h_addr == '0) && (v_addr == '0);
    frame_cnt_d  = frame_tick ? frame_cnt_q + 5'd1 : frame_cnt_q;
    blink_d      = (frame_tick && frame_cnt_q == 5'd31) ? !blink_q : blink_q;
    cur_hit_d    = pix_valid && blink_q && (cell_x == cx_q) && (cell_y == cy_q) &&
                   (py == GLYPH_W'(15));
    pix_on       = pix_on || cur_hit_q;
`endif
    vga_data_d   = pix_on ? RGB_FG : RGB_BG;
  end

  // Character buffer write port; reads are registered through font_ascii_q
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CLR_ALL;
      cx_q         <= '0;
      cy_q         <= '0;
      clr_x_q      <= '0;
      clr_y_q      <= '0;
      ch_ready_q   <= 1'b0;
      font_ascii_q <= '0;
      font_row_q   <= '0;
      font_col_q   <= '0;
      in_text_q    <= 1'b0;
      vga_data_q   <= '0;
`ifdef VGA_TEXT_CURSOR_EN
      blink_q      <= 1'b1;
      frame_cnt_q  <= '0;
      cur_hit_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      clr_x_q      <= clr_x_d;
      clr_y_q      <= clr_y_d;
      ch_ready_q   <= ch_ready_d;
      font_ascii_q <= font_ascii_d;
      font_row_q   <= font_row_d;
      font_col_q   <= font_col_d;
      in_text_q    <= in_text_d;
      vga_data_q   <= vga_data_d;
`ifdef VGA_TEXT_CURSOR_EN
      blink_q      <= blink_d;
      frame_cnt_q  <= frame_cnt_d;
      cur_hit_q    <= cur_hit_d;
`endif
    end
  end

  assign ch_if.ch_ready = ch_ready_q;
  assign font_ascii     = font_ascii_q;
  assign font_row       = font_row_q;
  assign font_col       = font_col_q;
  assign vga_data       = vga_data_q;

endmodule

// File: tb/tb_vga_text_ctrl.sv
// Randomized bench for vga_text_ctrl against a cell-array/cursor reference model.
// Cursor-underline expectations are included when VGA_TEXT_CURSOR_EN is defined.
module tb_vga_text_ctrl;

  localparam logic [23:0] FG = 24'hFFFFFF;
  localparam logic [23:0] BG = 24'h000000;

  logic        clk;
  logic        rst;
  logic [9:0]  h_addr;
  logic [9:0]  v_addr;
  logic        pix_valid;
  logic [7:0]  font_ascii;
  logic [3:0]  font_row;
  logic [3:0]  font_col;
  logic        font_data;
  logic [23:0] vga_data;

  vga_text_ctrl_if ch_if ();

  vga_text_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .ch_if      (ch_if.slave),
    .h_addr     (h_addr),
    .v_addr     (v_addr),
    .pix_valid  (pix_valid),
    .font_ascii (font_ascii),
    .font_row   (font_row),
    .font_col   (font_col),
    .font_data  (font_data),
    .vga_data   (vga_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synthetic font: space is blank, other glyphs are a fixed arithmetic pattern
  function automatic bit glyph(input int a, input int r, input int c);
    if (a == 32) return 1'b0;
    return ((a * 7 + r * 3 + c * 5) % 4) == 0;
  endfunction

  assign font_data = glyph(int'(font_ascii), int'(font_row), int'(font_col));

  int           n_checks;
  int           n_fail;
  logic [7:0]   mb [30][70];
  int           mx, my;
  bit           blink_m;
  int           tick_m;
  logic [23:0]  exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (mb[y, x]) mb[y][x] = 8'h20;
    mx = 0;
    my = 0;
    blink_m = 1'b1;
    tick_m = 0;
  endtask

  // One pixel per cycle; checks stage-1 font outputs now and vga_data of the previous pixel
  task automatic pix_cycle(input int h, input int v, input bit pv);
    int cxp, cyp, pxp, pyp;
    int ch;
    bit on;
    cxp = h / 9;
    pxp = h % 9;
    cyp = v / 16;
    pyp = v % 16;
    ch  = (h < 630) ? int'(mb[cyp][cxp]) : 0;
    h_addr    = 10'(h);
    v_addr    = 10'(v);
    pix_valid = pv;
    on = pv && (h < 630) && glyph(ch, pyp, pxp);
`ifdef VGA_TEXT_CURSOR_EN
    if (pv && blink_m && cxp == mx && cyp == my && pyp == 15) on = 1'b1;
    if (pv && h == 0 && v == 0) begin
      tick_m++;
      if (tick_m == 32) begin
        tick_m  = 0;
        blink_m = !blink_m;
      end
    end
`endif
    exp_q.push_back(on ? FG : BG);
    @(negedge clk);
    chk("font_row", 32'(font_row), 32'(pyp));
    chk("font_col", 32'(font_col), 32'(pxp));
    if (h < 630) chk("font_ascii", 32'(font_ascii), 32'(ch));
    if (exp_q.size() >= 2) chk("vga_data", 32'(vga_data), 32'(exp_q.pop_front()));
  endtask

  task automatic scan_all();
    exp_q.delete();
    for (int y = 0; y < 30; y++)
      for (int x = 0; x < 70; x++)
        pix_cycle(x * 9 + int'($urandom_range(0, 8)), y * 16 + int'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)));
    pix_valid = 1'b0;
  endtask

  task automatic wait_clear();
    int n;
    n = 0;
    while (!ch_if.ch_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("clr_all_cycles", 32'(n), 32'd2100);
  endtask

  // Reset for one cycle, optionally presenting a character that must be dropped
  task automatic do_reset(input bit present);
    rst            = 1'b1;
    pix_valid      = 1'b0;
    ch_if.ch_valid = present;
    ch_if.ch_data  = 8'h5A;
    @(negedge clk);
    chk("rst_ch_ready", 32'(ch_if.ch_ready), 32'd0);
    chk("rst_font_ascii", 32'(font_ascii), 32'd0);
    chk("rst_font_row", 32'(font_row), 32'd0);
    chk("rst_font_col", 32'(font_col), 32'd0);
    chk("rst_vga_data", 32'(vga_data), 32'd0);
    rst            = 1'b0;
    ch_if.ch_valid = 1'b0;
    model_reset();
    wait_clear();
  endtask

  task automatic send_char(input logic [7:0] c);
    int n;
    bit clr;
    n = 0;
    while (!ch_if.ch_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("ch_ready_wait", 32'(ch_if.ch_ready), 32'd1);
    pix_valid      = 1'b0;
    ch_if.ch_valid = 1'b1;
    ch_if.ch_data  = c;
    @(negedge clk);
    ch_if.ch_valid = 1'b0;
    clr = 1'b0;
    if (c >= 8'h20 && c <= 8'h7E) begin
      mb[my][mx] = c;
      if (mx == 69) begin
        mx  = 0;
        my  = (my + 1) % 30;
        clr = 1'b1;
      end else begin
        mx++;
      end
    end else if (c == 8'h0A) begin
      mx  = 0;
      my  = (my + 1) % 30;
      clr = 1'b1;
    end else if (c == 8'h08 && mx > 0) begin
      mx--;
      mb[my][mx] = 8'h20;
    end
    if (clr) for (int x = 0; x < 70; x++) mb[my][x] = 8'h20;
    n = 0;
    while (!ch_if.ch_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_low_cycles", 32'(n), clr ? 32'd70 : 32'd0);
  endtask

  function automatic logic [7:0] rand_code();
    int r;
    logic [7:0] c;
    r = int'($urandom_range(0, 99));
    if (r < 70)      c = 8'($urandom_range(32, 126));
    else if (r < 80) c = 8'h0A;
    else if (r < 90) c = 8'h08;
    else if (r < 95) c = 8'($urandom_range(127, 255));
    else begin
      c = 8'($urandom_range(0, 31));
      if (c == 8'h08 || c == 8'h0A) c = 8'h07;
    end
    return c;
  endfunction

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst            = 1'b1;
    h_addr         = '0;
    v_addr         = '0;
    pix_valid      = 1'b0;
    ch_if.ch_valid = 1'b0;
    ch_if.ch_data  = '0;
    model_reset();

    do_reset(1'b0);
    scan_all();

    // 'A' at (0,0) then probe pixel (4,5)
    send_char(8'h41);
    exp_q.delete();
    pix_cycle(4, 5, 1'b1);
    pix_cycle(4, 5, 1'b1);
    pix_cycle(4, 5, 1'b1);

    // Outside text columns or blanked: background
    exp_q.delete();
    pix_cycle(635, 5, 1'b1);
    pix_cycle(635, 5, 1'b1);
    pix_cycle(4, 5, 1'b0);
    pix_cycle(4, 5, 1'b0);
    pix_cycle(629, 100, 1'b1);

    // Full-row wrap clears the next line
    do_reset(1'b0);
    for (int i = 0; i < 70; i++) send_char(8'h42);
    send_char(8'h43);
    scan_all();

    // Newline wrap from the last row, backspace at column 0, ignored code
    for (int i = 0; i < 28; i++) send_char(8'h0A);
    send_char(8'h0A);
    send_char(8'h08);
    send_char(8'h07);
    send_char(8'h44);
    scan_all();

`ifdef VGA_TEXT_CURSOR_EN
    do_reset(1'b0);
    send_char(8'h0A);
    send_char(8'h0A);
    send_char(8'h78);
    send_char(8'h79);
    send_char(8'h7A);
    exp_q.delete();
    pix_cycle(30, 47, 1'b1);
    pix_cycle(30, 47, 1'b1);
    for (int i = 0; i < 32; i++) pix_cycle(0, 0, 1'b1);
    pix_cycle(30, 47, 1'b1);
    pix_cycle(30, 47, 1'b1);
    pix_valid = 1'b0;
`endif

    // Random character stream with interleaved random pixel traffic
    for (int blk = 0; blk < 8; blk++) begin
      for (int i = 0; i < 50; i++) send_char(rand_code());
      exp_q.delete();
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 15) == 0)
          pix_cycle(0, 0, 1'b1);
        else
          pix_cycle(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
                    1'($urandom_range(0, 3) != 0));
      end
      pix_valid = 1'b0;
    end
    scan_all();

    // Reset in the middle of a line clear with a character presented
    send_char(8'h51);
    ch_if.ch_valid = 1'b1;
    ch_if.ch_data  = 8'h0A;
    @(negedge clk);
    ch_if.ch_valid = 1'b0;
    repeat (10) @(negedge clk);
    do_reset(1'b1);
    scan_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
